// File: rtl/rgb_frame_capture.sv
// rgb_frame_capture: samples an RGB565 DE/VSYNC video stream and writes a
// decimated still frame per start request. Optional: CAPTURE_LINE_CHECK_EN.
module rgb_frame_capture #(
  parameter int H_AREA     = 1024,
  parameter int V_AREA     = 545,
  parameter int IMG_WIDTH  = 200,
  parameter int IMG_HEIGHT = 138,
  parameter int DEC_X      = 5,
  parameter int DEC_Y      = 3
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        start,
  input  logic        LCD_DE,
  input  logic        LCD_HSYNC,
  input  logic        LCD_VSYNC,
  input  logic [4:0]  LCD_R,
  input  logic [5:0]  LCD_G,
  input  logic [4:0]  LCD_B,
  output logic [14:0] mem_ad,
  output logic [15:0] mem_din,
  output logic        mem_wre,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE
  } state_t;

  localparam logic [7:0]  DX1   = 8'(DEC_X - 1);
  localparam logic [7:0]  DY1   = 8'(DEC_Y - 1);
  localparam logic [7:0]  W8    = 8'(IMG_WIDTH);
  localparam logic [7:0]  H8    = 8'(IMG_HEIGHT);
  localparam logic [14:0] W15   = 15'(IMG_WIDTH);
  localparam logic [14:0] TOTAL = 15'(IMG_WIDTH * IMG_HEIGHT);

  // Geometry sanity term; folded away, kept so all parameters are referenced.
  localparam bit unused_cfg_ok =
    (IMG_WIDTH * DEC_X <= H_AREA) && (IMG_HEIGHT * DEC_Y <= V_AREA);

  logic        s_de_q, s_hs_q, s_vs_q;
  logic [15:0] s_rgb_q;
  logic        de_prev_q, vs_prev_q;
  logic        unused_hs;

  state_t      state_q;
  logic [7:0]  xph_q, yph_q, col_q, row_q;
  logic [14:0] base_q, wcnt_q;
  logic [14:0] mem_ad_q;
  logic [15:0] mem_din_q;
  logic        mem_wre_q, busy_q, done_q, err_q;

  logic        de_fall, vs_fall, store_d, last_wr_d, chk_err;
  logic [14:0] mem_ad_d;

  assign unused_hs = s_hs_q;

  // First pipeline register: sample the video bus and keep previous levels.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      s_de_q    <= 1'b0;
      s_hs_q    <= 1'b1;
      s_vs_q    <= 1'b1;
      s_rgb_q   <= 16'd0;
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b1;
    end else begin
      s_de_q    <= LCD_DE;
      s_hs_q    <= LCD_HSYNC;
      s_vs_q    <= LCD_VSYNC;
      s_rgb_q   <= {LCD_R, LCD_G, LCD_B};
      de_prev_q <= s_de_q;
      vs_prev_q <= s_vs_q;
    end
  end

  // Edge detects and the store decision for the sampled pixel.
  always_comb begin
    de_fall   = de_prev_q & ~s_de_q;
    vs_fall   = vs_prev_q & ~s_vs_q;
    store_d   = (state_q == CAPTURE) && s_de_q &&
                (xph_q == 8'd0) && (yph_q == 8'd0) &&
                (col_q < W8) && (row_q < H8);
    last_wr_d = store_d && (wcnt_q == TOTAL - 15'd1);
    mem_ad_d  = base_q + {7'd0, col_q};
  end

`ifdef CAPTURE_LINE_CHECK_EN
  localparam int LW = $clog2(H_AREA + 2);
  localparam int FW = $clog2(V_AREA + 2);
  localparam logic [LW-1:0] H_LEN = LW'(H_AREA);
  localparam logic [FW-1:0] V_LEN = FW'(V_AREA);

  logic [LW-1:0] len_q;
  logic [FW-1:0] lines_q;

  // Per-line DE length and per-frame line count while capturing.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      len_q   <= '0;
      lines_q <= '0;
    end else if (state_q == WAIT_VS) begin
      len_q   <= '0;
      lines_q <= '0;
    end else if (state_q == CAPTURE) begin
      if (s_de_q) begin
        len_q <= len_q + 1'b1;
      end else if (de_fall) begin
        len_q   <= '0;
        lines_q <= lines_q + 1'b1;
      end
    end
  end

  // Length mismatch flags for the line or frame just closed.
  always_comb begin
    chk_err = 1'b0;
    if (state_q == CAPTURE) begin
      if (de_fall && (len_q != H_LEN)) chk_err = 1'b1;
      if (vs_fall && (lines_q != V_LEN)) chk_err = 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  // Capture FSM with registered memory-port and status outputs.
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      xph_q     <= 8'd0;
      yph_q     <= 8'd0;
      col_q     <= 8'd0;
      row_q     <= 8'd0;
      base_q    <= 15'd0;
      wcnt_q    <= 15'd0;
      mem_ad_q  <= 15'd0;
      mem_din_q <= 16'd0;
      mem_wre_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mem_wre_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT_VS;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            wcnt_q  <= 15'd0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            base_q  <= 15'd0;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            state_q <= CAPTURE;
            xph_q   <= 8'd0;
            yph_q   <= 8'd0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            base_q  <= 15'd0;
          end
        end
        CAPTURE: begin
          if (chk_err) err_q <= 1'b1;
          if (wcnt_q == TOTAL) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (vs_fall && !last_wr_d) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            if (store_d) begin
              mem_ad_q  <= mem_ad_d;
              mem_din_q <= s_rgb_q;
              mem_wre_q <= 1'b1;
              col_q     <= col_q + 8'd1;
              wcnt_q    <= wcnt_q + 15'd1;
            end
            if (s_de_q) begin
              xph_q <= (xph_q == DX1) ? 8'd0 : xph_q + 8'd1;
            end else if (de_fall) begin
              xph_q <= 8'd0;
              col_q <= 8'd0;
              yph_q <= (yph_q == DY1) ? 8'd0 : yph_q + 8'd1;
              if (yph_q == 8'd0) begin
                row_q  <= row_q + 8'd1;
                base_q <= base_q + W15;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ad    = mem_ad_q;
  assign mem_din   = mem_din_q;
  assign mem_wre   = mem_wre_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = err_q;

endmodule
